// File: rtl/decode_stage_if.sv
// Fetch/writeback-to-decode inputs and the ID/EX register bundle of decode_stage.
// master drives fetch/WB inputs and observes ID/EX; slave is the decode stage.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned ILEN = 32;
  localparam int unsigned RW   = 5;

  logic [ILEN-1:0] instr_in;
  logic            instr_valid;
  logic [XLEN-1:0] pc_in;
  logic            flush;
  logic            wb_we;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            stall_out;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [RW-1:0]   id_rs1;
  logic [RW-1:0]   id_rs2;
  logic [RW-1:0]   id_rd;
  logic [2:0]      id_funct3;
  logic [3:0]      id_alu_op;
  logic            id_alu_src;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_reg_write;
  logic            id_branch;
  logic            id_jump;
  logic            id_illegal;

  modport master (
    output instr_in, instr_valid, pc_in, flush, wb_we, wb_rd, wb_data,
    input  stall_out, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_alu_op, id_alu_src,
           id_mem_read, id_mem_write, id_reg_write, id_branch, id_jump, id_illegal
  );

  modport slave (
    input  instr_in, instr_valid, pc_in, flush, wb_we, wb_rd, wb_data,
    output stall_out, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_alu_op, id_alu_src,
           id_mem_read, id_mem_write, id_reg_write, id_branch, id_jump, id_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: register file, immediate/control generation, load-use
// hazard detection and the ID/EX pipeline register.
module decode_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREG    = 32,
  parameter bit          REG_CLR = 1'b1
) (
  input logic           clk1,
  input logic           rst,
  decode_stage_if.slave bus
);
  localparam int unsigned RW = $clog2(NREG);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [RW-1:0]   rs1;
  logic [RW-1:0]   rs2;
  logic [RW-1:0]   rd;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  ctrl_t           ctrl_c;
  ctrl_t           ctrl_n;
  logic [XLEN-1:0] imm_c;
  logic            use_rs1_c;
  logic            use_rs2_c;
  logic [XLEN-1:0] rs1_data_c;
  logic [XLEN-1:0] rs2_data_c;
  logic            hazard_c;
  logic            bubble_c;
  logic            wb_hit_c;

  logic [XLEN-1:0] regs [NREG];

  // Instruction fields and the five immediate formats, sign-extended from bit 31
  assign instr  = bus.instr_in;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  // funct3 -> ALU op; instr[30] picks SRA always, SUB only for register-register
  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt,
                                        input logic is_reg);
    case (f3)
      3'd0:    alu_fn = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'd1:    alu_fn = ALU_SLL;
      3'd2:    alu_fn = ALU_SLT;
      3'd3:    alu_fn = ALU_SLTU;
      3'd4:    alu_fn = ALU_XOR;
      3'd5:    alu_fn = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  endfunction

  // Opcode decode: control bundle, immediate and which sources are really read
  always_comb begin
    ctrl_c    = '0;
    imm_c     = '0;
    use_rs1_c = 1'b0;
    use_rs2_c = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_op    = alu_fn(funct3, instr[30], 1'b1);
        use_rs1_c        = 1'b1;
        use_rs2_c        = 1'b1;
      end
      OP_IMM: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_op    = alu_fn(funct3, instr[30], 1'b0);
        imm_c            = imm_i;
        use_rs1_c        = 1'b1;
      end
      OP_LOAD: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_op    = ALU_ADD;
        imm_c            = imm_i;
        use_rs1_c        = 1'b1;
      end
      OP_STORE: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_op    = ALU_ADD;
        imm_c            = imm_s;
        use_rs1_c        = 1'b1;
        use_rs2_c        = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_c.branch = 1'b1;
        ctrl_c.alu_op = ALU_SUB;
        imm_c         = imm_b;
        use_rs1_c     = 1'b1;
        use_rs2_c     = 1'b1;
      end
      OP_JAL: begin
        ctrl_c.jump      = 1'b1;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_op    = ALU_ADD;
        imm_c            = imm_j;
      end
      OP_JALR: begin
        ctrl_c.jump      = 1'b1;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_op    = ALU_ADD;
        imm_c            = imm_i;
        use_rs1_c        = 1'b1;
      end
      OP_LUI: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_op    = ALU_PASS;
        imm_c            = imm_u;
      end
      OP_AUIPC: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_op    = ALU_ADD;
        imm_c            = imm_u;
      end
      default: ctrl_c.illegal = 1'b1;
    endcase
  end

  // Register file write port; x0 is never written
  always_ff @(posedge clk1) begin
    if (rst && REG_CLR) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (bus.wb_we && (bus.wb_rd != '0)) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Read ports with same-cycle writeback bypass; x0 reads zero
  assign wb_hit_c = bus.wb_we && (bus.wb_rd != '0);

  always_comb begin
    rs1_data_c = regs[rs1];
    if (rs1 == '0)                        rs1_data_c = '0;
    else if (wb_hit_c && bus.wb_rd == rs1) rs1_data_c = bus.wb_data;
  end

  always_comb begin
    rs2_data_c = regs[rs2];
    if (rs2 == '0)                        rs2_data_c = '0;
    else if (wb_hit_c && bus.wb_rd == rs2) rs2_data_c = bus.wb_data;
  end

  // Load in ID/EX whose rd feeds a live source of the instruction now in decode
  assign hazard_c = bus.id_valid && bus.id_mem_read && (bus.id_rd != '0) &&
                    bus.instr_valid && !bus.flush &&
                    ((use_rs1_c && (rs1 == bus.id_rd)) ||
                     (use_rs2_c && (rs2 == bus.id_rd)));

  assign bus.stall_out = hazard_c && !rst;
  assign bubble_c      = bus.flush || !bus.instr_valid || hazard_c;

  always_comb begin
    ctrl_n = ctrl_c;
    if (bubble_c) ctrl_n = '0;
  end

  // ID/EX pipeline register; a bubble clears only id_valid and the control bits
  always_ff @(posedge clk1) begin
    if (rst) begin
      bus.id_valid     <= 1'b0;
      bus.id_pc        <= '0;
      bus.id_rs1_data  <= '0;
      bus.id_rs2_data  <= '0;
      bus.id_imm       <= '0;
      bus.id_rs1       <= '0;
      bus.id_rs2       <= '0;
      bus.id_rd        <= '0;
      bus.id_funct3    <= '0;
      bus.id_alu_op    <= '0;
      bus.id_alu_src   <= 1'b0;
      bus.id_mem_read  <= 1'b0;
      bus.id_mem_write <= 1'b0;
      bus.id_reg_write <= 1'b0;
      bus.id_branch    <= 1'b0;
      bus.id_jump      <= 1'b0;
      bus.id_illegal   <= 1'b0;
    end else begin
      bus.id_valid     <= !bubble_c;
      bus.id_pc        <= bus.pc_in;
      bus.id_rs1_data  <= rs1_data_c;
      bus.id_rs2_data  <= rs2_data_c;
      bus.id_imm       <= imm_c;
      bus.id_rs1       <= rs1;
      bus.id_rs2       <= rs2;
      bus.id_rd        <= rd;
      bus.id_funct3    <= funct3;
      bus.id_alu_op    <= ctrl_n.alu_op;
      bus.id_alu_src   <= ctrl_n.alu_src;
      bus.id_mem_read  <= ctrl_n.mem_read;
      bus.id_mem_write <= ctrl_n.mem_write;
      bus.id_reg_write <= ctrl_n.reg_write;
      bus.id_branch    <= ctrl_n.branch;
      bus.id_jump      <= ctrl_n.jump;
      bus.id_illegal   <= ctrl_n.illegal;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized checks of decode_stage against a behavioural model
// of RV32I decode, the register file and the load-use stall rule.
module tb_decode_stage;
  logic clk1 = 1'b0;
  logic rst;

  decode_stage_if bus();

  decode_stage #(.XLEN(32), .NREG(32), .REG_CLR(1'b1)) dut (
    .clk1(clk1),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk1 = ~clk1;

  typedef struct packed {
    logic        valid, full, has_imm, chk_alu, chk_src, u1, u2;
    logic        mr, mw, rw, br, jmp, ill, alu_src;
    logic [3:0]  alu_op;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, rs1d, rs2d, imm;
  } exp_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] rf [32];
  exp_t        m;
  logic        last_stall;
  logic        obs_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural meaning of an instruction word, built from the ISA tables
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t       e;
    logic [3:0] base [8];
    int         sx;
    logic [2:0] f3;
    base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    sx   = int'($signed(w));
    f3   = w[14:12];
    e = '0;
    e.valid = 1'b1; e.full = 1'b1; e.has_imm = 1'b1; e.chk_alu = 1'b1; e.chk_src = 1'b1;
    e.pc = pc; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.f3 = f3;
    case (w[6:0])
      7'b0110011: begin
        e.rw = 1; e.u1 = 1; e.u2 = 1; e.has_imm = 0;
        e.alu_op = base[f3] + 4'((f3 == 3'd0 || f3 == 3'd5) && w[30]);
      end
      7'b0010011: begin
        e.rw = 1; e.u1 = 1; e.alu_src = 1; e.imm = 32'(sx >>> 20);
        e.alu_op = base[f3] + 4'(f3 == 3'd5 && w[30]);
      end
      7'b0000011: begin
        e.rw = 1; e.mr = 1; e.u1 = 1; e.alu_src = 1; e.chk_alu = 0; e.imm = 32'(sx >>> 20);
      end
      7'b0100011: begin
        e.mw = 1; e.u1 = 1; e.u2 = 1; e.alu_src = 1; e.chk_alu = 0;
        e.imm = 32'((sx >>> 25) * 32 + int'(w[11:7]));
      end
      7'b1100011: begin
        e.br = 1; e.u1 = 1; e.u2 = 1; e.alu_op = 4'd1;
        e.imm = 32'((sx >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 +
                    int'(w[11:8]) * 2);
      end
      7'b1101111: begin
        e.jmp = 1; e.rw = 1; e.chk_alu = 0; e.chk_src = 0;
        e.imm = 32'((sx >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 +
                    int'(w[30:21]) * 2);
      end
      7'b1100111: begin
        e.jmp = 1; e.rw = 1; e.u1 = 1; e.chk_alu = 0; e.chk_src = 0; e.imm = 32'(sx >>> 20);
      end
      7'b0110111: begin
        e.rw = 1; e.alu_src = 1; e.alu_op = 4'd10; e.imm = w & 32'hFFFF_F000;
      end
      7'b0010111: begin
        e.rw = 1; e.alu_src = 1; e.chk_alu = 0; e.imm = w & 32'hFFFF_F000;
      end
      default: begin
        e.ill = 1; e.has_imm = 0; e.chk_alu = 0; e.chk_src = 0;
      end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rf_rd(input logic [4:0] i);
    if (i == 5'd0) return 32'd0;
    if (bus.wb_we && bus.wb_rd == i) return bus.wb_data;
    return rf[i];
  endfunction

  // One clock: check stall before the edge, advance the model, check ID/EX after it
  task automatic cycle();
    exp_t        d;
    logic        exp_stall;
    logic [31:0] r1, r2;
    @(negedge clk1); #1;
    d = ref_decode(bus.instr_in, bus.pc_in);
    exp_stall = !rst && m.valid && m.mr && (m.rd != 5'd0) && bus.instr_valid && !bus.flush &&
                ((d.u1 && d.rs1 == m.rd) || (d.u2 && d.rs2 == m.rd));
    obs_stall = bus.stall_out;
    check("stall_out", 32'(bus.stall_out), 32'(exp_stall));
    r1 = rf_rd(d.rs1);
    r2 = rf_rd(d.rs2);
    if (rst) begin
      m = '0; m.full = 1; m.has_imm = 1; m.chk_alu = 1; m.chk_src = 1;
    end else if (bus.flush || !bus.instr_valid || exp_stall) begin
      m = '0; m.chk_alu = 1; m.chk_src = 1;
    end else begin
      m = d; m.rs1d = r1; m.rs2d = r2;
    end
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    end else if (bus.wb_we && bus.wb_rd != 5'd0) begin
      rf[bus.wb_rd] = bus.wb_data;
    end
    last_stall = exp_stall;
    @(posedge clk1); #1;
    check("id_valid",     32'(bus.id_valid),     32'(m.valid));
    check("id_mem_read",  32'(bus.id_mem_read),  32'(m.mr));
    check("id_mem_write", 32'(bus.id_mem_write), 32'(m.mw));
    check("id_reg_write", 32'(bus.id_reg_write), 32'(m.rw));
    check("id_branch",    32'(bus.id_branch),    32'(m.br));
    check("id_jump",      32'(bus.id_jump),      32'(m.jmp));
    check("id_illegal",   32'(bus.id_illegal),   32'(m.ill));
    if (m.chk_alu) check("id_alu_op",  32'(bus.id_alu_op),  32'(m.alu_op));
    if (m.chk_src) check("id_alu_src", 32'(bus.id_alu_src), 32'(m.alu_src));
    if (m.full) begin
      check("id_pc",       bus.id_pc,       m.pc);
      check("id_rs1_data", bus.id_rs1_data, m.rs1d);
      check("id_rs2_data", bus.id_rs2_data, m.rs2d);
      check("id_rs1",      32'(bus.id_rs1),    32'(m.rs1));
      check("id_rs2",      32'(bus.id_rs2),    32'(m.rs2));
      check("id_rd",       32'(bus.id_rd),     32'(m.rd));
      check("id_funct3",   32'(bus.id_funct3), 32'(m.f3));
      if (m.has_imm) check("id_imm", bus.id_imm, m.imm);
    end
  endtask

  initial begin
    logic [6:0]  ops [12];
    logic [31:0] w;
    logic [31:0] pc;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000};
    m = '0;
    last_stall = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rst = 1'b1;
    bus.instr_in = 32'd0; bus.instr_valid = 1'b0; bus.pc_in = 32'd0; bus.flush = 1'b0;
    bus.wb_we = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
    cycle();
    cycle();
    check("rst_valid", 32'(bus.id_valid), 32'd0);
    rst = 1'b0;

    // ADDI x1,x0,5
    bus.instr_in = 32'h0050_0093; bus.instr_valid = 1'b1; bus.pc_in = 32'h10;
    cycle();
    check("t1_rd", 32'(bus.id_rd), 32'd1);
    check("t1_imm", bus.id_imm, 32'd5);
    check("t1_alu_op", 32'(bus.id_alu_op), 32'd0);
    check("t1_alu_src", 32'(bus.id_alu_src), 32'd1);
    check("t1_reg_write", 32'(bus.id_reg_write), 32'd1);
    check("t1_valid", 32'(bus.id_valid), 32'd1);

    // ADD x3,x2,x2 while WB writes x2
    bus.instr_in = 32'h0021_01B3; bus.pc_in = 32'h11;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h1234;
    cycle();
    bus.wb_we = 1'b0;
    check("t2_rs1_data", bus.id_rs1_data, 32'h1234);
    check("t2_rs2_data", bus.id_rs2_data, 32'h1234);

    // LW x5,0(x1) then dependent ADD x6,x5,x5
    bus.instr_in = 32'h0000_A283; bus.pc_in = 32'h12;
    cycle();
    bus.instr_in = 32'h0052_8333; bus.pc_in = 32'h13;
    cycle();
    check("t3_stall", 32'(obs_stall), 32'd1);
    check("t3_bubble", 32'(bus.id_valid), 32'd0);
    cycle();
    check("t3_stall_gone", 32'(obs_stall), 32'd0);
    check("t3_add_valid", 32'(bus.id_valid), 32'd1);
    check("t3_add_rd", 32'(bus.id_rd), 32'd6);

    // Flush over a pending hazard, plus a WB write to x0
    bus.instr_in = 32'h0000_A283; bus.pc_in = 32'h14;
    cycle();
    bus.instr_in = 32'h0052_8333; bus.pc_in = 32'h15; bus.flush = 1'b1;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF;
    cycle();
    check("t4_stall", 32'(obs_stall), 32'd0);
    check("t4_bubble", 32'(bus.id_valid), 32'd0);
    bus.flush = 1'b0; bus.wb_we = 1'b0;
    bus.instr_in = 32'h0000_03B3; bus.pc_in = 32'h16;
    cycle();
    check("t4_x0_rs1", bus.id_rs1_data, 32'd0);
    check("t4_x0_rs2", bus.id_rs2_data, 32'd0);

    // Illegal word, then BEQ with offset -4
    bus.instr_in = 32'hFFFF_FFFF; bus.pc_in = 32'h17;
    cycle();
    check("t5_illegal", 32'(bus.id_illegal), 32'd1);
    check("t5_ill_regwr", 32'(bus.id_reg_write), 32'd0);
    check("t5_ill_valid", 32'(bus.id_valid), 32'd1);
    bus.instr_in = 32'hFE00_0EE3; bus.pc_in = 32'h18;
    cycle();
    check("t5_beq_imm", bus.id_imm, 32'hFFFF_FFFC);
    check("t5_beq_branch", 32'(bus.id_branch), 32'd1);
    check("t5_beq_alu_op", 32'(bus.id_alu_op), 32'd1);

    // Reset during a load-use stall
    bus.instr_in = 32'h0000_A283; bus.pc_in = 32'h19;
    cycle();
    bus.instr_in = 32'h0052_8333; bus.pc_in = 32'h1A; rst = 1'b1;
    cycle();
    check("t6_stall", 32'(obs_stall), 32'd0);
    check("t6_valid", 32'(bus.id_valid), 32'd0);
    check("t6_pc", bus.id_pc, 32'd0);
    rst = 1'b0;
    bus.instr_in = 32'h0021_01B3; bus.pc_in = 32'h1B;
    cycle();
    check("t6_x2_cleared", bus.id_rs1_data, 32'd0);

    // Randomized traffic with small register indices to provoke hazards
    pc = 32'h100;
    for (int k = 0; k < 800; k++) begin
      if (!last_stall) begin
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 11)];
        if (w[6:0] == 7'b0000000) w[6:0] = 7'($urandom);
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        bus.instr_in = w;
        bus.pc_in = pc;
        pc = pc + 32'd1;
      end
      bus.instr_valid = ($urandom_range(0, 7) != 0);
      bus.flush       = ($urandom_range(0, 7) == 0);
      bus.wb_we       = 1'($urandom_range(0, 1));
      bus.wb_rd       = 5'($urandom_range(0, 7));
      bus.wb_data     = $urandom;
      rst             = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
